// File: rtl/cheat_table_if.sv
// cheat_table_if: SNES bus, programming and statistics signals of the cheat table.
interface cheat_table_if #(
    parameter int IDX_W = 5,
    parameter int CNT_W = 8
);
    logic [23:0]      SNES_ADDR;
    logic [7:0]       SNES_ROM_DATA;
    logic [7:0]       SNES_DATA;
    logic             SNES_rd_strobe;
    logic             snescmd_wr_strobe;
    logic             snescmd_unlock;
    logic             pgm_we;
    logic [1:0]       pgm_sel;
    logic [IDX_W-1:0] pgm_idx;
    logic [31:0]      pgm_in;
    logic             stat_req;
    logic [IDX_W-1:0] stat_idx;
    logic             stat_ack;
    logic [CNT_W-1:0] stat_count;
    logic [7:0]       data_out;
    logic             cheat_hit;

    modport master (
        output SNES_ADDR, SNES_ROM_DATA, SNES_DATA, SNES_rd_strobe, snescmd_wr_strobe,
               snescmd_unlock, pgm_we, pgm_sel, pgm_idx, pgm_in, stat_req, stat_idx,
        input  stat_ack, stat_count, data_out, cheat_hit
    );
    modport slave (
        input  SNES_ADDR, SNES_ROM_DATA, SNES_DATA, SNES_rd_strobe, snescmd_wr_strobe,
               snescmd_unlock, pgm_we, pgm_sel, pgm_idx, pgm_in, stat_req, stat_idx,
        output stat_ack, stat_count, data_out, cheat_hit
    );
endinterface

// File: rtl/cheat_table.sv
// cheat_table: patch slots that substitute ROM bytes on matching SNES reads,
// with one-shot arming, snescmd control and per-slot saturating hit counters.
module cheat_table #(
    parameter int NUM_SLOTS = 16,
    parameter int IDX_W     = 5,
    parameter int CNT_W     = 8
) (
    input logic clk,
    input logic rst,
    cheat_table_if.slave bus
);
    logic [23:0]          addr  [NUM_SLOTS];
    logic [7:0]           data  [NUM_SLOTS];
    logic [7:0]           cmp   [NUM_SLOTS];
    logic [CNT_W-1:0]     count [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] en, cmp_en, oneshot, armed, match, win;
    logic                 global_en, stats_en, g_cmd, g_next, s_next;
    logic                 cmd_go, cmd_arm, pgm_flags, stat_ack_q;
    logic [7:0]           hit_data;
    logic [CNT_W-1:0]     stat_val, stat_count_q;

    // win is one-hot on the lowest matching slot; out-of-range stat_idx reads 0
    always_comb begin
        match    = '0;
        win      = '0;
        hit_data = 8'h00;
        stat_val = '0;
        for (int i = 0; i < NUM_SLOTS; i++) begin
            match[i] = global_en & en[i] & armed[i] & (bus.SNES_ADDR == addr[i]) &
                       (~cmp_en[i] | (bus.SNES_ROM_DATA == cmp[i]));
            if (match[i] && win == '0) begin
                win[i]   = 1'b1;
                hit_data = data[i];
            end
            if (bus.stat_idx == IDX_W'(i))
                stat_val = count[i];
        end
    end

    // programming flags are applied on top of the snescmd result so they win
    always_comb begin
        cmd_go    = bus.snescmd_unlock & bus.snescmd_wr_strobe & (bus.SNES_ADDR[8:0] == 9'h0);
        cmd_arm   = cmd_go & (bus.SNES_DATA == 8'h86);
        pgm_flags = bus.pgm_we & (bus.pgm_sel == 2'd3);
        g_cmd     = (cmd_go && bus.SNES_DATA == 8'h82) ? 1'b1 :
                    (cmd_go && bus.SNES_DATA == 8'h83) ? 1'b0 : global_en;
        g_next    = pgm_flags ? ((g_cmd & ~bus.pgm_in[4]) | bus.pgm_in[0]) : g_cmd;
        s_next    = pgm_flags ? ((stats_en & ~bus.pgm_in[5]) | bus.pgm_in[1]) : stats_en;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                addr[i]  <= '0;
                data[i]  <= '0;
                cmp[i]   <= '0;
                count[i] <= '0;
            end
            en           <= '0;
            cmp_en       <= '0;
            oneshot      <= '0;
            armed        <= '0;
            global_en    <= 1'b0;
            stats_en     <= 1'b0;
            stat_ack_q   <= 1'b0;
            stat_count_q <= '0;
        end else begin
            global_en  <= g_next;
            stats_en   <= s_next;
            stat_ack_q <= bus.stat_req;
            if (bus.stat_req)
                stat_count_q <= stat_val;
            // later assignments override earlier ones: hit < snescmd < pgm
            for (int i = 0; i < NUM_SLOTS; i++) begin
                if (bus.SNES_rd_strobe && win[i]) begin
                    if (stats_en && count[i] != '1)
                        count[i] <= count[i] + 1'b1;
                    if (oneshot[i])
                        armed[i] <= 1'b0;
                end
                if (cmd_arm)
                    armed[i] <= 1'b1;
                if (bus.pgm_we && bus.pgm_idx == IDX_W'(i)) begin
                    if (bus.pgm_sel == 2'd0) begin
                        addr[i]  <= bus.pgm_in[31:8];
                        data[i]  <= bus.pgm_in[7:0];
                        armed[i] <= 1'b1;
                    end
                    if (bus.pgm_sel == 2'd1) begin
                        cmp[i]     <= bus.pgm_in[7:0];
                        en[i]      <= bus.pgm_in[8];
                        cmp_en[i]  <= bus.pgm_in[9];
                        oneshot[i] <= bus.pgm_in[10];
                    end
                    if (bus.pgm_sel == 2'd2) begin
                        count[i] <= '0;
                        armed[i] <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.cheat_hit  = ~rst & |match;
    assign bus.data_out   = rst ? 8'h00 : hit_data;
    assign bus.stat_ack   = stat_ack_q;
    assign bus.stat_count = stat_count_q;
endmodule

// File: tb/tb_cheat_table.sv
// tb_cheat_table: directed checks of matching, priority, one-shot, counters,
// snescmd control, flag collisions and the statistics read port.
module tb_cheat_table;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_fail = 0;

    cheat_table_if bus ();
    cheat_table dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pgm(input logic [1:0] sel, input logic [4:0] idx, input logic [31:0] din);
        bus.pgm_we = 1'b1; bus.pgm_sel = sel; bus.pgm_idx = idx; bus.pgm_in = din;
        tick();
        bus.pgm_we = 1'b0;
    endtask

    task automatic strobe(input logic [23:0] a, input logic [7:0] rom);
        bus.SNES_ADDR = a; bus.SNES_ROM_DATA = rom; bus.SNES_rd_strobe = 1'b1;
        tick();
        bus.SNES_rd_strobe = 1'b0;
    endtask

    task automatic snescmd(input logic [7:0] d, input logic unlock);
        bus.SNES_ADDR = 24'h002A00; bus.SNES_DATA = d;
        bus.snescmd_unlock = unlock; bus.snescmd_wr_strobe = 1'b1;
        tick();
        bus.snescmd_wr_strobe = 1'b0; bus.snescmd_unlock = 1'b0;
    endtask

    task automatic get_count(input logic [4:0] idx, output logic [7:0] c, output logic a);
        bus.stat_req = 1'b1; bus.stat_idx = idx;
        tick();
        bus.stat_req = 1'b0;
        a = bus.stat_ack; c = bus.stat_count;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        n_chk++; if (bus.cheat_hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit: got %b want 0", bus.cheat_hit); end
        n_chk++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data: got %h want 00", bus.data_out); end
        n_chk++; if (bus.stat_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b want 0", bus.stat_ack); end
        n_chk++; if (bus.stat_count !== 8'h00) begin n_fail++; $display("FAIL reset_count: got %h want 00", bus.stat_count); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        logic [7:0] c; logic a;
        pgm(2'd0, 5'd3, {24'h00C123, 8'hEA});
        pgm(2'd1, 5'd3, 32'h100);
        pgm(2'd3, 5'd0, 32'h3);
        bus.SNES_ADDR = 24'h00C124; bus.SNES_ROM_DATA = 8'h00; #1;
        n_chk++; if (bus.cheat_hit !== 1'b0) begin n_fail++; $display("FAIL basic_miss_hit: got %b want 0", bus.cheat_hit); end
        n_chk++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL basic_miss_data: got %h want 00", bus.data_out); end
        bus.SNES_ADDR = 24'h00C123; #1;
        n_chk++; if (bus.cheat_hit !== 1'b1) begin n_fail++; $display("FAIL basic_hit: got %b want 1", bus.cheat_hit); end
        n_chk++; if (bus.data_out !== 8'hEA) begin n_fail++; $display("FAIL basic_data: got %h want EA", bus.data_out); end
        strobe(24'h00C123, 8'h00);
        get_count(5'd3, c, a);
        n_chk++; if (a !== 1'b1) begin n_fail++; $display("FAIL basic_ack: got %b want 1", a); end
        n_chk++; if (c !== 8'h01) begin n_fail++; $display("FAIL basic_count: got %h want 01", c); end
    endtask

    task automatic test_priority();
        logic [7:0] c; logic a;
        pgm(2'd0, 5'd2, {24'h001000, 8'h11});
        pgm(2'd1, 5'd2, 32'h100);
        pgm(2'd0, 5'd5, {24'h001000, 8'h22});
        pgm(2'd1, 5'd5, 32'h100);
        bus.SNES_ADDR = 24'h001000; #1;
        n_chk++; if (bus.data_out !== 8'h11) begin n_fail++; $display("FAIL prio_data: got %h want 11", bus.data_out); end
        strobe(24'h001000, 8'h00);
        get_count(5'd2, c, a);
        n_chk++; if (c !== 8'h01) begin n_fail++; $display("FAIL prio_count2: got %h want 01", c); end
        get_count(5'd5, c, a);
        n_chk++; if (c !== 8'h00) begin n_fail++; $display("FAIL prio_count5: got %h want 00", c); end
    endtask

    task automatic test_cmp();
        pgm(2'd0, 5'd7, {24'h002000, 8'h33});
        pgm(2'd1, 5'd7, 32'h35A);
        bus.SNES_ADDR = 24'h002000; bus.SNES_ROM_DATA = 8'hA5; #1;
        n_chk++; if (bus.cheat_hit !== 1'b0) begin n_fail++; $display("FAIL cmp_miss: got %b want 0", bus.cheat_hit); end
        bus.SNES_ROM_DATA = 8'h5A; #1;
        n_chk++; if (bus.cheat_hit !== 1'b1) begin n_fail++; $display("FAIL cmp_hit: got %b want 1", bus.cheat_hit); end
        n_chk++; if (bus.data_out !== 8'h33) begin n_fail++; $display("FAIL cmp_data: got %h want 33", bus.data_out); end
    endtask

    task automatic test_oneshot();
        pgm(2'd0, 5'd9, {24'h003000, 8'h44});
        pgm(2'd1, 5'd9, 32'h500);
        bus.SNES_ADDR = 24'h003000; #1;
        n_chk++; if (bus.cheat_hit !== 1'b1) begin n_fail++; $display("FAIL oneshot_first: got %b want 1", bus.cheat_hit); end
        strobe(24'h003000, 8'h00);
        n_chk++; if (bus.cheat_hit !== 1'b0) begin n_fail++; $display("FAIL oneshot_second: got %b want 0", bus.cheat_hit); end
        snescmd(8'h86, 1'b0);
        bus.SNES_ADDR = 24'h003000; #1;
        n_chk++; if (bus.cheat_hit !== 1'b0) begin n_fail++; $display("FAIL oneshot_locked: got %b want 0", bus.cheat_hit); end
        snescmd(8'h86, 1'b1);
        bus.SNES_ADDR = 24'h003000; #1;
        n_chk++; if (bus.cheat_hit !== 1'b1) begin n_fail++; $display("FAIL oneshot_rearm: got %b want 1", bus.cheat_hit); end
        n_chk++; if (bus.data_out !== 8'h44) begin n_fail++; $display("FAIL oneshot_data: got %h want 44", bus.data_out); end
        pgm(2'd0, 5'd16, {24'h004000, 8'h55});
        pgm(2'd1, 5'd16, 32'h100);
        bus.SNES_ADDR = 24'h004000; #1;
        n_chk++; if (bus.cheat_hit !== 1'b0) begin n_fail++; $display("FAIL oob_pgm: got %b want 0", bus.cheat_hit); end
    endtask

    task automatic test_saturate();
        logic [7:0] c; logic a;
        repeat (300) strobe(24'h00C123, 8'h00);
        get_count(5'd3, c, a);
        n_chk++; if (c !== 8'hFF) begin n_fail++; $display("FAIL sat_count: got %h want FF", c); end
        bus.SNES_ADDR = 24'h00C123; bus.SNES_rd_strobe = 1'b1;
        bus.pgm_we = 1'b1; bus.pgm_sel = 2'd2; bus.pgm_idx = 5'd3;
        tick();
        bus.SNES_rd_strobe = 1'b0; bus.pgm_we = 1'b0;
        get_count(5'd3, c, a);
        n_chk++; if (c !== 8'h00) begin n_fail++; $display("FAIL clr_vs_hit_count: got %h want 00", c); end
        bus.SNES_ADDR = 24'h003000; bus.SNES_rd_strobe = 1'b1;
        bus.pgm_we = 1'b1; bus.pgm_sel = 2'd2; bus.pgm_idx = 5'd9;
        tick();
        bus.SNES_rd_strobe = 1'b0; bus.pgm_we = 1'b0;
        n_chk++; if (bus.cheat_hit !== 1'b1) begin n_fail++; $display("FAIL clr_vs_hit_armed: got %b want 1", bus.cheat_hit); end
        get_count(5'd9, c, a);
        n_chk++; if (c !== 8'h00) begin n_fail++; $display("FAIL clr_vs_hit_count9: got %h want 00", c); end
    endtask

    task automatic test_stat();
        logic [7:0] c; logic a;
        bus.SNES_ADDR = 24'h00C123; bus.SNES_rd_strobe = 1'b1;
        bus.stat_req = 1'b1; bus.stat_idx = 5'd3;
        tick();
        bus.SNES_rd_strobe = 1'b0; bus.stat_req = 1'b0;
        n_chk++; if (bus.stat_ack !== 1'b1) begin n_fail++; $display("FAIL stat_pre_ack: got %b want 1", bus.stat_ack); end
        n_chk++; if (bus.stat_count !== 8'h00) begin n_fail++; $display("FAIL stat_pre_count: got %h want 00", bus.stat_count); end
        get_count(5'd3, c, a);
        n_chk++; if (c !== 8'h01) begin n_fail++; $display("FAIL stat_post_count: got %h want 01", c); end
        tick();
        n_chk++; if (bus.stat_ack !== 1'b0) begin n_fail++; $display("FAIL stat_ack_pulse: got %b want 0", bus.stat_ack); end
        n_chk++; if (bus.stat_count !== 8'h01) begin n_fail++; $display("FAIL stat_hold: got %h want 01", bus.stat_count); end
        bus.stat_req = 1'b1; bus.stat_idx = 5'd5; tick();
        n_chk++; if ({bus.stat_ack, bus.stat_count} !== 9'h100) begin n_fail++; $display("FAIL b2b_5: got %h want 100", {bus.stat_ack, bus.stat_count}); end
        bus.stat_idx = 5'd2; tick();
        n_chk++; if ({bus.stat_ack, bus.stat_count} !== 9'h101) begin n_fail++; $display("FAIL b2b_2: got %h want 101", {bus.stat_ack, bus.stat_count}); end
        bus.stat_idx = 5'd20; tick();
        bus.stat_req = 1'b0;
        n_chk++; if ({bus.stat_ack, bus.stat_count} !== 9'h100) begin n_fail++; $display("FAIL b2b_oob: got %h want 100", {bus.stat_ack, bus.stat_count}); end
    endtask

    task automatic test_collision();
        logic [7:0] c; logic a;
        snescmd(8'h83, 1'b1);
        bus.SNES_ADDR = 24'h00C123; #1;
        n_chk++; if (bus.cheat_hit !== 1'b0) begin n_fail++; $display("FAIL cmd_83: got %b want 0", bus.cheat_hit); end
        snescmd(8'h82, 1'b1);
        bus.SNES_ADDR = 24'h00C123; #1;
        n_chk++; if (bus.cheat_hit !== 1'b1) begin n_fail++; $display("FAIL cmd_82: got %b want 1", bus.cheat_hit); end
        snescmd(8'h84, 1'b1);
        bus.SNES_ADDR = 24'h00C123; #1;
        n_chk++; if (bus.cheat_hit !== 1'b1) begin n_fail++; $display("FAIL cmd_other: got %b want 1", bus.cheat_hit); end
        pgm(2'd3, 5'd0, 32'h10);
        n_chk++; if (bus.cheat_hit !== 1'b0) begin n_fail++; $display("FAIL pgm_clr_global: got %b want 0", bus.cheat_hit); end
        bus.SNES_ADDR = 24'h002A00; bus.SNES_DATA = 8'h83;
        bus.snescmd_unlock = 1'b1; bus.snescmd_wr_strobe = 1'b1;
        bus.pgm_we = 1'b1; bus.pgm_sel = 2'd3; bus.pgm_in = 32'h1;
        tick();
        bus.snescmd_wr_strobe = 1'b0; bus.snescmd_unlock = 1'b0; bus.pgm_we = 1'b0;
        bus.SNES_ADDR = 24'h00C123; #1;
        n_chk++; if (bus.cheat_hit !== 1'b1) begin n_fail++; $display("FAIL pgm_over_cmd: got %b want 1", bus.cheat_hit); end
        pgm(2'd3, 5'd0, 32'h20);
        strobe(24'h001000, 8'h00);
        get_count(5'd2, c, a);
        n_chk++; if (c !== 8'h01) begin n_fail++; $display("FAIL stats_off: got %h want 01", c); end
    endtask

    task automatic test_reset_mid_stat();
        logic [7:0] c; logic a;
        bus.SNES_ADDR = 24'h00C123;
        bus.stat_req = 1'b1; bus.stat_idx = 5'd2;
        tick();
        bus.stat_req = 1'b0;
        n_chk++; if (bus.stat_ack !== 1'b1) begin n_fail++; $display("FAIL pre_rst_ack: got %b want 1", bus.stat_ack); end
        rst = 1'b1; #1;
        n_chk++; if (bus.stat_ack !== 1'b0) begin n_fail++; $display("FAIL rst_ack: got %b want 0", bus.stat_ack); end
        n_chk++; if (bus.stat_count !== 8'h00) begin n_fail++; $display("FAIL rst_count: got %h want 00", bus.stat_count); end
        n_chk++; if (bus.cheat_hit !== 1'b0) begin n_fail++; $display("FAIL rst_hit: got %b want 0", bus.cheat_hit); end
        n_chk++; if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL rst_data: got %h want 00", bus.data_out); end
        tick();
        rst = 1'b0;
        tick();
        n_chk++; if (bus.cheat_hit !== 1'b0) begin n_fail++; $display("FAIL post_rst_hit: got %b want 0", bus.cheat_hit); end
        get_count(5'd2, c, a);
        n_chk++; if (c !== 8'h00) begin n_fail++; $display("FAIL post_rst_count: got %h want 00", c); end
    endtask

    initial begin
        bus.SNES_ADDR = '0; bus.SNES_ROM_DATA = '0; bus.SNES_DATA = '0;
        bus.SNES_rd_strobe = 1'b0; bus.snescmd_wr_strobe = 1'b0; bus.snescmd_unlock = 1'b0;
        bus.pgm_we = 1'b0; bus.pgm_sel = '0; bus.pgm_idx = '0; bus.pgm_in = '0;
        bus.stat_req = 1'b0; bus.stat_idx = '0;
        test_reset();
        test_basic();
        test_priority();
        test_cmp();
        test_oneshot();
        test_saturate();
        test_stat();
        test_collision();
        test_reset_mid_stat();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
